// File: rtl/minimips_pkg.sv
// Shared MiniMIPS definitions: fetch FSM states, instruction field positions and opcodes.
package minimips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUF  = 2'd2
  } fetch_state_t;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 9;
  localparam int RT_MSB    = 8;
  localparam int RT_LSB    = 6;
  localparam int RD_MSB    = 5;
  localparam int RD_LSB    = 3;
  localparam int FUNCT_MSB = 2;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 5;
  localparam int IMM_LSB   = 0;

  // Opcodes as decoded by main_control
  localparam logic [3:0] OPC_RTYPE = 4'h0;
  localparam logic [3:0] OPC_ADDI  = 4'h1;
  localparam logic [3:0] OPC_LW    = 4'h2;
  localparam logic [3:0] OPC_SW    = 4'h3;
  localparam logic [3:0] OPC_BEQ   = 4'h4;
  localparam logic [3:0] OPC_JMP   = 4'h5;
  localparam logic [3:0] OPC_LUI   = 4'h6;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction fetched while downstream was stalled.
module fetch_skid_buffer
  import minimips_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc1,
  output logic               full,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc1
);

  // Flush wins so a redirect never lets a stale entry survive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full  <= 1'b0;
      instr <= '0;
      pc1   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc1   <= load_pc1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// MiniMIPS fetch + IF/ID register: PC, imem req/ack, skid buffer, branch flush, field split.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_bubbles counters.
module fetch_decode_stage
  import minimips_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               valid,
  output logic [3:0]         op,
  output logic [2:0]         rs,
  output logic [2:0]         rt,
  output logic [2:0]         rd,
  output logic [2:0]         funct,
  output logic [5:0]         imm,
  output logic [PC_W-1:0]    pc_plus1
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  fetch_state_t       state, state_d;
  logic [PC_W-1:0]    fetch_pc, fetch_pc_d;
  logic [INSTR_W-1:0] ir, ir_d;
  logic               valid_d;
  logic [PC_W-1:0]    pc1, pc1_d;
  logic               pend, pend_d;
  logic [PC_W-1:0]    tgt, tgt_d;
  logic               buf_load, buf_drain, buf_flush, buf_full;
  logic [INSTR_W-1:0] buf_instr;
  logic [PC_W-1:0]    buf_pc1;

  fetch_skid_buffer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .drain      (buf_drain),
    .flush      (buf_flush),
    .load_instr (imem_rdata),
    .load_pc1   (fetch_pc + PC_W'(1)),
    .full       (buf_full),
    .instr      (buf_instr),
    .pc1        (buf_pc1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      ir       <= '0;
      valid    <= 1'b0;
      pc1      <= RESET_PC;
      pend     <= 1'b0;
      tgt      <= RESET_PC;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      ir       <= ir_d;
      valid    <= valid_d;
      pc1      <= pc1_d;
      pend     <= pend_d;
      tgt      <= tgt_d;
    end
  end

  // Output register: a taken branch kills, a stall holds, otherwise a bubble unless overwritten below
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    ir_d       = ir;
    valid_d    = (stall && !branch_taken) ? valid : 1'b0;
    pc1_d      = pc1;
    pend_d     = pend;
    tgt_d      = tgt;
    buf_load   = 1'b0;
    buf_drain  = 1'b0;
    buf_flush  = 1'b0;
    imem_req   = 1'b0;
    case (state)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (branch_taken || pend) begin
            fetch_pc_d = branch_taken ? branch_target : tgt;
            pend_d     = 1'b0;
          end else if (!stall) begin
            ir_d       = imem_rdata;
            valid_d    = 1'b1;
            pc1_d      = fetch_pc + PC_W'(1);
            fetch_pc_d = fetch_pc + PC_W'(1);
          end else begin
            buf_load   = 1'b1;
            fetch_pc_d = fetch_pc + PC_W'(1);
            state_d    = BUF;
          end
        end else if (branch_taken) begin
          // The in-flight request must still complete; remember where to go afterwards
          pend_d = 1'b1;
          tgt_d  = branch_target;
        end
      end
      BUF: begin
        if (branch_taken) begin
          buf_flush  = 1'b1;
          fetch_pc_d = branch_target;
          state_d    = REQ;
        end else if (!stall && buf_full) begin
          buf_drain = 1'b1;
          ir_d      = buf_instr;
          pc1_d     = buf_pc1;
          valid_d   = 1'b1;
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr = fetch_pc;
  assign pc_plus1  = pc1;
  assign op        = ir[OP_MSB:OP_LSB];
  assign rs        = ir[RS_MSB:RS_LSB];
  assign rt        = ir[RT_MSB:RT_LSB];
  assign rd        = ir[RD_MSB:RD_LSB];
  assign funct     = ir[FUNCT_MSB:FUNCT_LSB];
  assign imm       = ir[IMM_MSB:IMM_LSB];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (valid && !stall && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (state != IDLE && !valid && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Instruction fetch and IF/ID register stage of the MiniMIPS processor, directly upstream of `main_control`. Maintains the program counter, runs a req/ack handshake to instruction memory, holds the current 16-bit instruction, and splits it into the fields the decoder and register file consume: `op[3:0]` drives `main_control`. Handles stall back-pressure with a one-entry buffer and flushes on taken branches.

## Interface
- `PC_W`, 16: program-counter / word-address width.
- `INSTR_W`, 16: instruction width; field positions fixed for 16.
- `RESET_PC`, 0: first fetch address after reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  word address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  `imem_rdata` valid this cycle; ignored when `imem_req`=0.
- `imem_rdata`  in  INSTR_W  fetched instruction.
- `stall`  in  1  downstream cannot accept a new instruction.
- `branch_taken`  in  1  one-cycle pulse (`branch` & condition from `isequal`).
- `branch_target`  in  PC_W  redirect address, sampled with `branch_taken`.
- `valid`  out  1  instruction register holds a live instruction.
- `op`  out  4  instr[15:12].
- `rs`, `rt`, `rd`  out  3 each  instr[11:9], [8:6], [5:3].
- `funct`  out  3  instr[2:0].
- `imm`  out  6  instr[5:0], raw; sign extension is downstream.
- `pc_plus1`  out  PC_W  address of the held instruction + 1.

## Operation
- States: IDLE, REQ, BUF.
- IDLE (one cycle after reset): `imem_req`=0; go to REQ.
- REQ: `imem_req`=1, `imem_addr`=fetch_pc.
  - ack, with `branch_taken` now or redirect pending: discard data; fetch_pc←target; clear pending; stay REQ.
  - ack, `stall`=0: IR←rdata, `valid`←1, `pc_plus1`←fetch_pc+1, fetch_pc←fetch_pc+1; stay REQ.
  - ack, `stall`=1: buffer←rdata with its pc+1; fetch_pc+1; go BUF.
  - No ack: hold address. `branch_taken` sets redirect-pending and latches target; the in-flight request completes and is then discarded.
- BUF: `imem_req`=0.
  - `branch_taken`: drop buffer; fetch_pc←target; go REQ.
  - Else `stall`=0: IR←buffer, `valid`←1; go REQ.
- Output register:
  - `branch_taken` forces `valid`←0 at the next edge and overrides `stall`.
  - Else `stall`=1 holds IR and `valid`.
  - Else no instruction delivered: `valid`←0 (bubble).
- PC arithmetic wraps modulo 2^PC_W; 16'hFFFF+1 = 0.
- Field outputs are always driven combinationally from the IR, even when `valid`=0.

## Timing
- Reset values: state IDLE, `imem_req`=0, `imem_addr`=RESET_PC, IR=0 (so `op`=0000 and all fields 0), `valid`=0, `pc_plus1`=RESET_PC, buffer empty, redirect-pending clear.
- First request is visible 1 cycle after the `rst_n` edge.
- Latency: ack in cycle N gives `valid`=1 in cycle N+1.
- Zero-wait memory sustains 1 instruction/cycle.
- Taken branch in cycle N: `valid`=0 in N+1, and the target request is issued in N+1.
- Only one request is outstanding at a time. `imem_addr` changes only after an ack, a reset, or in IDLE/BUF.
- `rst_n`=0 mid-transaction: the request is abandoned, `imem_req`=0 after the edge, and a late ack is ignored.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds output `perf_fetched[31:0]`: count of cycles with `valid`=1 and `stall`=0.
  - Adds output `perf_bubbles[31:0]`: count of cycles with `valid`=0 after IDLE.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- `minimips_pkg`: state enum; field-position constants (OP_MSB/LSB, RS, RT, RD, FUNCT, IMM); opcode constants shared with `main_control`.
- Sub-module `fetch_skid_buffer` holds the one-entry instruction + pc_plus1 buffer (load, drain, flush).

## Test plan
- Reset release, zero-wait memory returning 16'h6123 at 0 and 16'h5240 at 1 → `op`=0110 on cycle 2, `op`=0101 on cycle 3, `pc_plus1`=1 then 2, `valid`=1.
- `stall`=1 for 3 cycles while an ack arrives → IR holds; `imem_req`=0 in BUF; after release the buffered instruction appears 1 cycle later with no skipped or duplicated address.
- `branch_taken` with target 16'h0040 in the same cycle as an ack → ack data discarded, `valid`=0 next cycle, next `imem_addr`=0040.
- `branch_taken` while memory has 3 wait states → `imem_addr` holds until ack, that data is dropped, and the following request goes to the target.
- fetch_pc=16'hFFFF, ack → `pc_plus1`=0 and next `imem_addr`=0.
- `rst_n`=0 during an outstanding request, ack arriving one cycle later → ignored; all outputs take their reset values.
- With `FETCH_PERF_EN`: 5 delivered instructions plus 2 bubbles → `perf_fetched`=5, `perf_bubbles`=2.
